// File: rtl/key_conditioner.sv
// Multi-channel key/switch conditioner: two-flop synchronizer, shared 1 kHz
// prescaler, per-channel tick-counted debounce and registered edge pulses.
module key_conditioner #(
    parameter int clk_mhz     = 50,
    parameter int w_in        = 8,
    parameter int debounce_ms = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [w_in-1:0] in,
    output logic [w_in-1:0] level,
    output logic [w_in-1:0] rise,
    output logic [w_in-1:0] fall,
    output logic            tick
);

    localparam int P  = clk_mhz * 1000;
    localparam int PW = $clog2(P);
    localparam int CW = $clog2(debounce_ms + 1);

    logic [PW-1:0]   r_presc;
    logic [w_in-1:0] r_sync1;
    logic [w_in-1:0] r_sync2;
    logic [CW-1:0]   r_cnt [w_in];
    logic [w_in-1:0] r_level;
    logic [w_in-1:0] r_rise;
    logic [w_in-1:0] r_fall;
    logic            w_tick;

    assign w_tick = (r_presc == PW'(P - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    // NOTE: r_cnt is a small per-channel register array, not a RAM, so it is
    // reset explicitly; a partial count must never survive a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < w_in; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < w_in; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_tick) begin
                    // Last tick of the stable window: accept and pulse together
                    if (r_cnt[i] == CW'(debounce_ms - 1)) begin
                        r_level[i] <= r_sync2[i];
                        r_rise[i]  <= r_sync2[i];
                        r_fall[i]  <= ~r_sync2[i];
                        r_cnt[i]   <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;
    assign tick  = w_tick;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (clk_mhz=1, debounce_ms=3, w_in=4) with an
// edge scoreboard holding the acceptable cycle window of every expected pulse.
module tb_key_conditioner;

    localparam int     CLK_MHZ = 1;
    localparam int     W_IN    = 4;
    localparam int     DEB_MS  = 3;
    localparam int     P       = CLK_MHZ * 1000;
    // Window from an input change to the level update, synchronizer included
    localparam longint LAT_LO  = 2 + (DEB_MS - 1) * P + 1;
    localparam longint LAT_HI  = 2 + DEB_MS * P;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [W_IN-1:0] in_r  = '0;
    logic [W_IN-1:0] level;
    logic [W_IN-1:0] rise;
    logic [W_IN-1:0] fall;
    logic            tick;

    key_conditioner #(
        .clk_mhz    (CLK_MHZ),
        .w_in       (W_IN),
        .debounce_ms(DEB_MS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in_r),
        .level(level),
        .rise (rise),
        .fall (fall),
        .tick (tick)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     ch;
        bit     is_rise;
        longint lo;
        longint hi;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_errors = 0;
    longint last_rise [W_IN];
    longint rel;
    longint c0;

    task automatic expect_edge(input int ch, input bit is_rise, input longint t0);
        exp_t e;
        e.ch      = ch;
        e.is_rise = is_rise;
        e.lo      = t0 + LAT_LO;
        e.hi      = t0 + LAT_HI;
        sb.push_back(e);
    endtask

    task automatic goto_pos(input longint t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_neg(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_tick(input logic exp, input string tag);
        n_checks++;
        assert (tick === exp) else begin
            n_errors++;
            $error("FAIL %s: tick=%b expected %b at cycle %0d", tag, tick, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        n_checks++;
        assert ({level, rise, fall, tick} === 13'b0) else begin
            n_errors++;
            $error("FAIL %s: level=%b rise=%b fall=%b tick=%b expected all 0",
                   tag, level, rise, fall, tick);
        end
    endtask

    task automatic check_sb_empty(input string tag);
        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL %s: %0d expected pulses outstanding, expected 0", tag, sb.size());
        end
    endtask

    task automatic wait_level(input int ch, input logic val, input longint limit, input string tag);
        while (level[ch] !== val && cyc < limit) @(negedge clk);
        n_checks++;
        assert (level[ch] === val) else begin
            n_errors++;
            $error("FAIL %s: level[%0d]=%b expected %b by cycle %0d", tag, ch, level[ch], val, limit);
        end
    endtask

    // Every pulse must match an outstanding scoreboard entry and land in its window
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                for (int i = 0; i < W_IN; i++) begin
                    if (rise[i] || fall[i]) begin
                        int idx = -1;
                        n_checks++;
                        assert (!(rise[i] && fall[i])) else begin
                            n_errors++;
                            $error("FAIL pulse_excl ch%0d: rise=%b fall=%b expected not both",
                                   i, rise[i], fall[i]);
                        end
                        for (int k = 0; k < sb.size(); k++) begin
                            if (idx < 0 && sb[k].ch == i && sb[k].is_rise == rise[i]) idx = k;
                        end
                        n_checks++;
                        assert (idx >= 0) else begin
                            n_errors++;
                            $error("FAIL unexpected_pulse ch%0d: rise=%b fall=%b at cycle %0d expected none",
                                   i, rise[i], fall[i], cyc);
                        end
                        if (idx >= 0) begin
                            n_checks++;
                            assert (cyc >= sb[idx].lo && cyc <= sb[idx].hi) else begin
                                n_errors++;
                                $error("FAIL pulse_window ch%0d: cycle %0d expected %0d..%0d",
                                       i, cyc, sb[idx].lo, sb[idx].hi);
                            end
                            sb.delete(idx);
                        end
                        n_checks++;
                        assert (level[i] === rise[i]) else begin
                            n_errors++;
                            $error("FAIL level_at_pulse ch%0d: level=%b expected %b", i, level[i], rise[i]);
                        end
                        if (rise[i]) last_rise[i] = cyc;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < W_IN; i++) last_rise[i] = -1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_zero("reset_state");

        // Tick period and clean press on channel 0
        rst_n = 1'b1;
        rel   = cyc;
        goto_pos(rel + 10);
        in_r[0] = 1'b1;
        c0 = cyc;
        expect_edge(0, 1'b1, c0);
        goto_neg(rel + 998);
        check_tick(1'b0, "tick_998");
        goto_neg(rel + 999);
        check_tick(1'b1, "tick_999");
        goto_neg(rel + 1000);
        check_tick(1'b0, "tick_1000");
        goto_neg(rel + 1999);
        check_tick(1'b1, "tick_1999");
        goto_neg(rel + 2000);
        check_tick(1'b0, "tick_2000");
        goto_neg(rel + 2999);
        check_tick(1'b1, "tick_2999");
        wait_level(0, 1'b1, c0 + LAT_HI + 5, "press_level0");
        n_checks++;
        assert (level[3:1] === 3'b000) else begin
            n_errors++;
            $error("FAIL press_others: level[3:1]=%b expected 000", level[3:1]);
        end
        check_sb_empty("press_sb");

        // Release on channel 0
        goto_pos(cyc + 20);
        in_r[0] = 1'b0;
        c0 = cyc;
        expect_edge(0, 1'b0, c0);
        wait_level(0, 1'b0, c0 + LAT_HI + 5, "release_level0");
        check_sb_empty("release_sb");

        // Bounce on channel 1: 100 toggles, 50 cycles apart, then settle at 1
        for (int k = 0; k < 100; k++) begin
            in_r[1] = ~in_r[1];
            repeat (50) begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        assert (level[1] === 1'b0) else begin
            n_errors++;
            $error("FAIL bounce_level1: level[1]=%b expected 0 while bouncing", level[1]);
        end
        in_r[1] = 1'b1;
        c0 = cyc;
        expect_edge(1, 1'b1, c0);
        wait_level(1, 1'b1, c0 + LAT_HI + 5, "bounce_settle_level1");
        check_sb_empty("bounce_sb");

        // Simultaneous press on channels 2 and 3
        goto_pos(cyc + 20);
        in_r[3:2] = 2'b11;
        c0 = cyc;
        expect_edge(2, 1'b1, c0);
        expect_edge(3, 1'b1, c0);
        wait_level(2, 1'b1, c0 + LAT_HI + 5, "simul_level2");
        wait_level(3, 1'b1, c0 + LAT_HI + 5, "simul_level3");
        n_checks++;
        assert (last_rise[2] === last_rise[3] && last_rise[2] >= 0) else begin
            n_errors++;
            $error("FAIL simul_same_cycle: rise2 at %0d rise3 at %0d expected equal",
                   last_rise[2], last_rise[3]);
        end

        // Drop channels 1..3 together
        goto_pos(cyc + 20);
        in_r[3:1] = 3'b000;
        c0 = cyc;
        for (int i = 1; i < W_IN; i++) expect_edge(i, 1'b0, c0);
        for (int i = 1; i < W_IN; i++) wait_level(i, 1'b0, c0 + LAT_HI + 5, "drop_level");
        check_sb_empty("drop_sb");

        // Reset mid-count on channel 0, then a fresh full debounce window
        goto_pos(cyc + 20);
        in_r[0] = 1'b1;
        c0 = cyc;
        goto_pos(c0 + 1500);
        rst_n = 1'b0;
        #1;
        check_zero("reset_entry");
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_zero("reset_hold");
        rst_n = 1'b1;
        c0 = cyc;
        expect_edge(0, 1'b1, c0);
        wait_level(0, 1'b1, c0 + LAT_HI + 5, "after_reset_level0");
        repeat (3) @(negedge clk);

        check_sb_empty("final_sb");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
